// File: rtl/aes_keyexp_seq.sv
// AES-128 key expansion engine: reads the cipher key, S-box and Rcon tables from a
// shared word memory and writes w[0..43] back, multiplexing the memory port with a CPU.
module aes_keyexp_seq #(
  parameter logic [8:0] KEY_BASE  = 9'd4,
  parameter logic [8:0] SBOX_BASE = 9'd8,
  parameter logic [8:0] RCON_BASE = 9'd72,
  parameter logic [8:0] DST_BASE  = 9'd96
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic        cpu_wen,
  input  logic [8:0]  cpu_addr,
  input  logic [31:0] cpu_din,
  output logic [31:0] cpu_dout,
  output logic        cpu_stall,
  output logic        mem_wen,
  output logic [8:0]  mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  typedef enum logic [2:0] {IDLE, KRD, KWR, SUB, RCN, WR, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] win_q [4];
  logic [31:0] win_d [4];
  logic [5:0]  idx_q, idx_d;
  logic [31:0] temp_q, temp_d;
  logic [1:0]  j_q, j_d;

  logic        eng_wen;
  logic [8:0]  eng_addr;
  logic [31:0] eng_din;
  logic [31:0] rot_w;
  logic [7:0]  sub_b;
  logic [7:0]  sbox_byte;
  logic [31:0] new_w;

  // Byte n of a word, byte 0 being bits 31:24.
  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] n);
    logic [7:0] r;
    case (n)
      2'd0:    r = w[31:24];
      2'd1:    r = w[23:16];
      2'd2:    r = w[15:8];
      default: r = w[7:0];
    endcase
    return r;
  endfunction

  assign rot_w     = {win_q[3][23:0], win_q[3][31:24]};
  assign sub_b     = byte_sel(rot_w, j_q);
  assign sbox_byte = byte_sel(mem_dout, sub_b[1:0]);
  assign new_w     = win_q[0] ^ ((idx_q[1:0] == 2'd0) ? temp_q : win_q[3]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= '{default: '0};
      idx_q   <= '0;
      temp_q  <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      idx_q   <= idx_d;
      temp_q  <= temp_d;
      j_q     <= j_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    idx_d    = idx_q;
    temp_d   = temp_q;
    j_d      = j_q;
    eng_wen  = 1'b0;
    eng_addr = '0;
    eng_din  = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = KRD;
          idx_d   = '0;
        end
      end
      KRD: begin
        eng_addr             = KEY_BASE + {3'b000, idx_q};
        win_d[idx_q[1:0]]    = mem_dout;
        state_d              = KWR;
      end
      KWR: begin
        eng_wen  = 1'b1;
        eng_addr = DST_BASE + {3'b000, idx_q};
        eng_din  = win_q[idx_q[1:0]];
        idx_d    = idx_q + 6'd1;
        if (idx_q == 6'd3) begin
          state_d = SUB;
          j_d     = '0;
        end else begin
          state_d = KRD;
        end
      end
      SUB: begin
        // Four S-box bytes shift into temp MSB-first, giving SubWord(RotWord(w[i-1])).
        eng_addr = SBOX_BASE + {3'b000, sub_b[7:2]};
        temp_d   = {temp_q[23:0], sbox_byte};
        j_d      = j_q + 2'd1;
        if (j_q == 2'd3) state_d = RCN;
      end
      RCN: begin
        eng_addr = RCON_BASE + {5'b00000, idx_q[5:2]} - 9'd1;
        temp_d   = temp_q ^ mem_dout;
        state_d  = WR;
      end
      WR: begin
        eng_wen  = 1'b1;
        eng_addr = DST_BASE + {3'b000, idx_q};
        eng_din  = new_w;
        win_d[0] = win_q[1];
        win_d[1] = win_q[2];
        win_d[2] = win_q[3];
        win_d[3] = new_w;
        idx_d    = idx_q + 6'd1;
        if (idx_q == 6'd43) begin
          state_d = DONE;
        end else if (idx_q[1:0] == 2'd3) begin
          state_d = SUB;
          j_d     = '0;
        end else begin
          state_d = WR;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == KRD) || (state_q == KWR) || (state_q == SUB) ||
                     (state_q == RCN) || (state_q == WR);
  assign done      = (state_q == DONE);
  assign cpu_stall = busy;
  assign cpu_dout  = mem_dout;

  always_comb begin
    if (busy) begin
      mem_wen  = eng_wen;
      mem_addr = eng_addr;
      mem_din  = eng_din;
    end else begin
      mem_wen  = cpu_wen;
      mem_addr = cpu_addr;
      mem_din  = cpu_din;
    end
  end

endmodule

// File: tb/tb_aes_keyexp_seq.sv
// Bench for aes_keyexp_seq: behavioural word memory, AES-128 key schedule reference
// built from GF(2^8) arithmetic, directed and random-key runs.
module tb_aes_keyexp_seq;

  localparam logic [8:0] KEY_BASE  = 9'd4;
  localparam logic [8:0] SBOX_BASE = 9'd8;
  localparam logic [8:0] RCON_BASE = 9'd72;
  localparam logic [8:0] DST_BASE  = 9'd96;
  localparam logic [31:0] SENT     = 32'hdeadbeef;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic        cpu_wen;
  logic [8:0]  cpu_addr;
  logic [31:0] cpu_din;
  logic [31:0] cpu_dout;
  logic        cpu_stall;
  logic        mem_wen;
  logic [8:0]  mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  logic [31:0] mem  [512];
  logic [31:0] snap [512];
  logic [7:0]  sbox [256];
  logic [7:0]  rcon [10];
  logic [31:0] key_w [4];
  logic [31:0] exp_w [44];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  aes_keyexp_seq #(
    .KEY_BASE (KEY_BASE),
    .SBOX_BASE(SBOX_BASE),
    .RCON_BASE(RCON_BASE),
    .DST_BASE (DST_BASE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .cpu_wen  (cpu_wen),
    .cpu_addr (cpu_addr),
    .cpu_din  (cpu_din),
    .cpu_dout (cpu_dout),
    .cpu_stall(cpu_stall),
    .mem_wen  (mem_wen),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  assign mem_dout = mem[mem_addr];
  always @(posedge clk) if (mem_wen) mem[mem_addr] <= mem_din;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [8:0] a, input logic [31:0] d);
    cpu_wen = 1'b1; cpu_addr = a; cpu_din = d;
    step();
    cpu_wen = 1'b0;
  endtask

  task automatic build_tables();
    logic [7:0] inv, r;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    r = 8'h01;
    for (int k = 0; k < 10; k++) begin
      rcon[k] = r;
      r = gmul(r, 8'h02);
    end
  endtask

  task automatic compute_expected();
    logic [31:0] t;
    for (int i = 0; i < 4; i++) exp_w[i] = key_w[i];
    for (int i = 4; i < 44; i++) begin
      t = exp_w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t = t ^ {rcon[i/4-1], 24'h000000};
      end
      exp_w[i] = exp_w[i-4] ^ t;
    end
  endtask

  task automatic prep_run(input bit random_key);
    if (random_key)
      for (int k = 0; k < 4; k++) key_w[k] = $urandom;
    for (int k = 0; k < 4; k++) cpu_wr(KEY_BASE + 9'(k), key_w[k]);
    for (int k = 0; k < 44; k++) cpu_wr(DST_BASE + 9'(k), SENT);
    compute_expected();
  endtask

  // Runs one expansion; probes add the concurrent CPU store, the stalled store and the ignored start.
  task automatic run_full(input bit probes);
    int n;
    start = 1'b1;
    if (probes) begin
      cpu_wen = 1'b1; cpu_addr = 9'd300; cpu_din = 32'hcafef00d;
    end
    step();
    start = 1'b0; cpu_wen = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    if (probes) chk("same_cycle_cpu_store", mem[300], 32'hcafef00d);
    n = 1;
    while (n < 300) begin
      if (probes && n == 20) begin
        cpu_wen = 1'b1; cpu_addr = 9'd200; cpu_din = 32'h12345678;
        #1 chk("stall_while_busy", {31'd0, cpu_stall}, 32'd1);
      end
      if (probes && n == 50) start = 1'b1;
      step();
      cpu_wen = 1'b0; start = 1'b0;
      if (!busy) break;
      n++;
    end
    chk("busy_cycles", n, 98);
    chk("done_pulse", {31'd0, done}, 32'd1);
    step();
    chk("done_low_after", {31'd0, done}, 32'd0);
    chk("idle_after_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_dst(input string tag);
    for (int k = 0; k < 44; k++) chk(tag, mem[DST_BASE + 9'(k)], exp_w[k]);
  endtask

  initial begin
    int n, bad;
    rst = 1'b1; start = 1'b0; cpu_wen = 1'b0; cpu_addr = '0; cpu_din = '0;
    build_tables();
    step();
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_stall", {31'd0, cpu_stall}, 32'd0);
    rst = 1'b0;
    step();

    for (int m = 0; m < 64; m++)
      cpu_wr(SBOX_BASE + 9'(m), {sbox[4*m], sbox[4*m+1], sbox[4*m+2], sbox[4*m+3]});
    for (int k = 0; k < 10; k++) cpu_wr(RCON_BASE + 9'(k), {rcon[k], 24'h000000});
    cpu_wr(9'd200, 32'h00000000);
    cpu_wr(9'd300, 32'h00000000);

    key_w[0] = 32'h2b7e1516; key_w[1] = 32'h28aed2a6;
    key_w[2] = 32'habf71588; key_w[3] = 32'h09cf4f3c;
    prep_run(1'b0);
    cpu_addr = KEY_BASE + 9'd1;
    #1 chk("cpu_dout_passthrough", cpu_dout, 32'h28aed2a6);

    run_full(1'b1);
    chk("fips_w4", mem[DST_BASE + 9'd4], 32'ha0fafe17);
    chk("fips_w5", mem[DST_BASE + 9'd5], 32'h88542cb1);
    chk("fips_w43", mem[DST_BASE + 9'd43], 32'hb6630ca6);
    chk("fips_w0", mem[DST_BASE], 32'h2b7e1516);
    check_dst("fips_dst");
    chk("stalled_store_blocked", mem[200], 32'h00000000);
    cpu_wr(9'd200, 32'h12345678);
    chk("idle_store_written", mem[200], 32'h12345678);

    for (int r = 0; r < 3; r++) begin
      prep_run(1'b1);
      run_full(1'b0);
      check_dst("rand_dst");
    end

    prep_run(1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    while (n < 40) begin step(); n++; end
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    snap = mem;
    step(); step();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) step();
    bad = 0;
    for (int k = 0; k < 512; k++) if (mem[k] !== snap[k]) bad++;
    chk("no_write_after_abort", bad, 0);
    bad = 0;
    for (int k = 0; k < 44; k++)
      if (snap[DST_BASE + 9'(k)] !== SENT && snap[DST_BASE + 9'(k)] !== exp_w[k]) bad++;
    chk("partial_words_valid", bad, 0);
    chk("partial_key_written", snap[DST_BASE], exp_w[0]);

    for (int k = 0; k < 44; k++) cpu_wr(DST_BASE + 9'(k), SENT);
    run_full(1'b0);
    check_dst("restart_dst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_keyexp_seq.md
AES_KEYEXP_SEQ -- requirements
Module: aes_keyexp_seq

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- KEY_BASE, 9'd4, word address of cipher key w[0..3].
- SBOX_BASE, 9'd8, first of 64 packed S-box words.
- RCON_BASE, 9'd72, first of 10 Rcon words.
- DST_BASE, 9'd96, word address where w[0..43] are written.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, the only clock; all state updates on its rising edge.
- rst, in, 1, asynchronous, active-high reset.
- start, in, 1, request to run key expansion.
- busy, out, 1, engine owns data memory.
- done, out, 1, one-cycle completion pulse.
- cpu_wen, in, 1, CPU store strobe.
- cpu_addr, in, 9, CPU word address.
- cpu_din, in, 32, CPU store data.
- cpu_dout, out, 32, CPU load data.
- cpu_stall, out, 1, CPU must hold its access.
- mem_wen, out, 1, data memory write enable.
- mem_addr, out, 9, data memory address.
- mem_din, out, 32, data memory write data.
- mem_dout, in, 32, data memory read data; combinational read, valid the same cycle as mem_addr.

Function
REQ-003 The block SHALL have FSM states IDLE, KRD, KWR, SUB, RCN, WR, DONE.
REQ-004 In IDLE and DONE, mem_wen/mem_addr/mem_din SHALL equal cpu_wen/cpu_addr/cpu_din combinationally; cpu_dout SHALL always equal mem_dout.
REQ-005 cpu_stall SHALL equal busy; while busy, the CPU strobe SHALL NOT reach memory.
REQ-006 busy SHALL be 1 in KRD, KWR, SUB, RCN and WR, and 0 otherwise.
REQ-007 start sampled high in IDLE SHALL move the FSM to KRD on the next cycle; a CPU access in that same cycle completes normally.
REQ-008 start SHALL be ignored while busy or in DONE.
REQ-009 Key copy, for k = 0..3:
- KRD drives mem_addr = KEY_BASE+k and captures mem_dout into window slot k.
- KWR writes that word to DST_BASE+k with mem_wen = 1.
REQ-010 The block SHALL hold a 4-word window of w[i-4..i-1] and a 6-bit word index i.
REQ-011 For i = 4..43 with i%4 == 0, SubWord(RotWord(w[i-1])) SHALL take four SUB cycles, j = 0..3.
- Byte b is byte j of RotWord(w[i-1]), with byte 0 = bits 31:24.
- mem_addr = SBOX_BASE + b[7:2]; the S-box byte is lane b[1:0] of mem_dout, lane 0 = bits 31:24.
- The result is assembled MSB-first.
REQ-012 After the SUB cycles, RCN SHALL read RCON_BASE + (i/4 - 1) and XOR the whole 32-bit word into temp.
REQ-013 WR SHALL write w[i] = w[i-4] ^ temp to DST_BASE+i with mem_wen = 1, where temp = w[i-1] when i%4 != 0; WR then shifts the window and increments i.
REQ-014 Address arithmetic SHALL be 9-bit modulo 512 with no range checking.
REQ-015 Sequence length SHALL be 8 + 10*6 + 30 = 98 busy cycles.
REQ-016 After the WR for i = 43, the FSM SHALL go to DONE for exactly one cycle with done = 1, then return to IDLE.
REQ-017 mem_wen SHALL be 0 in KRD, SUB and RCN.
REQ-018 A new start SHALL rerun the full sequence from KRD and overwrite the destination.

Reset
REQ-019 rst high SHALL immediately force:
- FSM = IDLE, busy = 0, done = 0;
- window = 0, i = 0, temp = 0.
REQ-020 Reset mid-operation SHALL abort with no further writes; words already written remain in memory.
REQ-021 After reset, memory ports SHALL revert to CPU passthrough.

Verification
REQ-022 Memory preloaded with key 2b7e1516 28aed2a6 abf71588 09cf4f3c plus S-box/Rcon tables; pulse start -> busy high for exactly 98 cycles, then done = 1 for one cycle.
REQ-023 Same run -> DST+4 = a0fafe17, DST+5 = 88542cb1, DST+43 = b6630ca6, DST+0..3 = key.
REQ-024 CPU store addr 200 data 12345678 while busy -> cpu_stall = 1 and addr 200 unchanged; the same store in IDLE -> written next edge.
REQ-025 start asserted at cycle 50 of a run -> ignored; the single run completes at cycle 98.
REQ-026 rst asserted at cycle 40 -> busy = 0 and done = 0 immediately, no writes after; restart -> full correct 98-cycle run.
REQ-027 start and cpu_wen (addr 300, data cafef00d) in the same IDLE cycle -> addr 300 written, engine starts next cycle.
